// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control path: controller states,
// opcode/funct fields, ALU control codes and datapath select encodings.
package mips_pkg;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11
    } ctrl_state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REGB  = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALURESULT = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT    = 2'b01;
    localparam logic [1:0] PCSRC_JUMP      = 2'b10;

    function automatic logic op_supported(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ)   || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// Maps the FSM's aluop request and the R-type funct field onto ALU control,
// flagging funct codes the ALU does not implement.
module alu_decoder
    import mips_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [2:0] alucont,
    output logic       illegal_funct
);

    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        alucont       = ALU_ADD;
        illegal_funct = 1'b0;
        case (aluop)
            ALUOP_SUB:   alucont = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FUNCT_ADD: alucont = ALU_ADD;
                    FUNCT_SUB: alucont = ALU_SUB;
                    FUNCT_AND: alucont = ALU_AND;
                    FUNCT_OR:  alucont = ALU_OR;
                    FUNCT_SLT: alucont = ALU_SLT;
                    default:   illegal_funct = 1'b1;
                endcase
            end
            default:     alucont = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM of the multicycle MIPS core: sequences fetch, decode,
// execute, memory and writeback, and drives every datapath select/enable.
module multicycle_controller
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pcen,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       alusrca,
    output logic       iord,
    output logic       memtoreg,
    output logic       regdst,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucont,
    output logic       illegal
);

    ctrl_state_t state, state_next;
    logic        pcwrite, branch, illegal_op, illegal_funct;
    logic [1:0]  aluop;

    // NOTE: state is sequential, so it is updated with non-blocking assignment;
    // blocking here would race with any other clocked reader of state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= FETCH;
        else       state <= state_next;
    end

    always_comb begin
        state_next = FETCH;
        case (state)
            FETCH:   state_next = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_next = MEMADR;
                    OP_RTYPE:     state_next = RTYPEEX;
                    OP_BEQ:       state_next = BEQEX;
                    OP_ADDI:      state_next = ADDIEX;
                    OP_J:         state_next = JEX;
                    default:      state_next = FETCH;
                endcase
            end
            MEMADR:  state_next = (op == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   state_next = MEMWB;
            RTYPEEX: state_next = RTYPEWB;
            ADDIEX:  state_next = ADDIWB;
            default: state_next = FETCH;
        endcase
    end

    always_comb begin
        pcwrite    = 1'b0;
        branch     = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        regwrite   = 1'b0;
        alusrca    = 1'b0;
        iord       = 1'b0;
        memtoreg   = 1'b0;
        regdst     = 1'b0;
        alusrcb    = SRCB_REGB;
        pcsrc      = PCSRC_ALURESULT;
        aluop      = ALUOP_ADD;
        illegal_op = 1'b0;
        case (state)
            FETCH: begin
                irwrite = 1'b1;
                pcwrite = 1'b1;
                alusrcb = SRCB_FOUR;
            end
            DECODE: begin
                alusrcb    = SRCB_IMMSH;
                illegal_op = !op_supported(op);
            end
            MEMADR, ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
            end
            MEMRD:   iord = 1'b1;
            MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
            end
            MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
            end
            RTYPEWB: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
            end
            BEQEX: begin
                alusrca = 1'b1;
                aluop   = ALUOP_SUB;
                pcsrc   = PCSRC_ALUOUT;
                branch  = 1'b1;
            end
            ADDIWB:  regwrite = 1'b1;
            JEX: begin
                pcwrite = 1'b1;
                pcsrc   = PCSRC_JUMP;
            end
            default: ;
        endcase
    end

    alu_decoder u_alu_decoder (
        .aluop         (aluop),
        .funct         (funct),
        .alucont       (alucont),
        .illegal_funct (illegal_funct)
    );

    // The decoder only flags funct when asked to decode it, i.e. in RTYPEEX.
    assign illegal = illegal_op | illegal_funct;
    assign pcen    = pcwrite | (branch & zero);

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class cycle
// by cycle and compares the full output bundle against hand-written vectors.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op, funct;
    logic       zero;
    logic       pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucont;
    logic       illegal;
    logic [15:0] outs;

    int checks = 0;
    int errors = 0;

    // {pcen,memwrite,irwrite,regwrite, alusrca,iord,memtoreg,regdst, alusrcb, pcsrc, alucont, illegal}
    localparam logic [15:0] V_FETCH   = 16'b1010_0000_01_00_010_0;
    localparam logic [15:0] V_DECODE  = 16'b0000_0000_11_00_010_0;
    localparam logic [15:0] V_DEC_ILL = 16'b0000_0000_11_00_010_1;
    localparam logic [15:0] V_MEMADR  = 16'b0000_1000_10_00_010_0;
    localparam logic [15:0] V_MEMRD   = 16'b0000_0100_00_00_010_0;
    localparam logic [15:0] V_MEMWB   = 16'b0001_0010_00_00_010_0;
    localparam logic [15:0] V_MEMWR   = 16'b0100_0100_00_00_010_0;
    localparam logic [15:0] V_RTYPEWB = 16'b0001_0001_00_00_010_0;
    localparam logic [15:0] V_BEQ_T   = 16'b1000_1000_00_01_110_0;
    localparam logic [15:0] V_BEQ_F   = 16'b0000_1000_00_01_110_0;
    localparam logic [15:0] V_ADDIEX  = 16'b0000_1000_10_00_010_0;
    localparam logic [15:0] V_ADDIWB  = 16'b0001_0000_00_00_010_0;
    localparam logic [15:0] V_JEX     = 16'b1000_0000_00_10_010_0;

    assign outs = {pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst,
                   alusrcb, pcsrc, alucont, illegal};

    multicycle_controller dut (
        .clk      (clk),
        .reset    (reset),
        .op       (op),
        .funct    (funct),
        .zero     (zero),
        .pcen     (pcen),
        .memwrite (memwrite),
        .irwrite  (irwrite),
        .regwrite (regwrite),
        .alusrca  (alusrca),
        .iord     (iord),
        .memtoreg (memtoreg),
        .regdst   (regdst),
        .alusrcb  (alusrcb),
        .pcsrc    (pcsrc),
        .alucont  (alucont),
        .illegal  (illegal)
    );

    always #5 clk = ~clk;

    // Each test starts and ends at the sample point (#1 after negedge) of a FETCH cycle.
    task automatic test_reset();
        reset = 1'b1;
        op    = 6'b111111;
        funct = 6'b000001;
        zero  = 1'b0;
        #1;
        if (outs !== V_FETCH) begin
            $display("FAIL reset_async outs got %b expected %b", outs, V_FETCH);
            errors++;
        end
        checks++;
        repeat (3) @(posedge clk);
        #1;
        if (outs !== V_FETCH) begin
            $display("FAIL reset_held outs got %b expected %b", outs, V_FETCH);
            errors++;
        end
        checks++;
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    task automatic test_lw();
        logic [15:0] exp [$];
        exp = '{V_FETCH, V_DECODE, V_MEMADR, V_MEMRD, V_MEMWB, V_FETCH};
        op    = 6'b100011;
        funct = 6'b101010;
        for (int i = 0; i < exp.size(); i++) begin
            if (outs !== exp[i]) begin
                $display("FAIL lw cycle %0d outs got %b expected %b", i, outs, exp[i]);
                errors++;
            end
            checks++;
            if (i < exp.size() - 1) begin
                @(negedge clk);
                #1;
            end
        end
    endtask

    task automatic test_sw();
        logic [15:0] exp [$];
        exp = '{V_FETCH, V_DECODE, V_MEMADR, V_MEMWR};
        op    = 6'b101011;
        funct = 6'b100010;
        for (int i = 0; i < exp.size(); i++) begin
            if (outs !== exp[i]) begin
                $display("FAIL sw cycle %0d outs got %b expected %b", i, outs, exp[i]);
                errors++;
            end
            checks++;
            @(negedge clk);
            #1;
        end
    endtask

    task automatic test_rtype();
        logic [5:0]  functs [6];
        logic [2:0]  alus   [6];
        logic        ills   [6];
        logic [15:0] exp    [$];
        functs = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000001};
        alus   = '{3'b010,    3'b110,    3'b000,    3'b001,    3'b111,    3'b010};
        ills   = '{1'b0,      1'b0,      1'b0,      1'b0,      1'b0,      1'b1};
        op = 6'b000000;
        for (int f = 0; f < 6; f++) begin
            funct = functs[f];
            exp = '{V_FETCH, V_DECODE, {12'b0000_1000_00_00, alus[f], ills[f]}, V_RTYPEWB};
            for (int i = 0; i < exp.size(); i++) begin
                if (outs !== exp[i]) begin
                    $display("FAIL rtype funct %b cycle %0d outs got %b expected %b",
                             functs[f], i, outs, exp[i]);
                    errors++;
                end
                checks++;
                @(negedge clk);
                #1;
            end
        end
    endtask

    task automatic test_beq(input logic z);
        logic [15:0] exp [$];
        exp = '{V_FETCH, V_DECODE, z ? V_BEQ_T : V_BEQ_F};
        op    = 6'b000100;
        funct = 6'b100101;
        zero  = z;
        for (int i = 0; i < exp.size(); i++) begin
            if (outs !== exp[i]) begin
                $display("FAIL beq zero=%0b cycle %0d outs got %b expected %b", z, i, outs, exp[i]);
                errors++;
            end
            checks++;
            if (i == 2) begin
                zero = ~z;
                #1;
                if (pcen !== ~z) begin
                    $display("FAIL beq_pcen_follows_zero pcen got %b expected %b", pcen, ~z);
                    errors++;
                end
                checks++;
                zero = z;
            end
            @(negedge clk);
            #1;
        end
        zero = 1'b0;
    endtask

    task automatic test_j_addi();
        logic [15:0] exp [$];
        exp = '{V_FETCH, V_DECODE, V_JEX, V_FETCH, V_DECODE, V_ADDIEX, V_ADDIWB};
        for (int i = 0; i < exp.size(); i++) begin
            op    = (i < 3) ? 6'b000010 : 6'b001000;
            funct = 6'b100010;
            #1;
            if (outs !== exp[i]) begin
                $display("FAIL j_addi cycle %0d outs got %b expected %b", i, outs, exp[i]);
                errors++;
            end
            checks++;
            @(negedge clk);
            #1;
        end
    endtask

    task automatic test_illegal_op();
        logic [15:0] exp [$];
        exp = '{V_FETCH, V_DEC_ILL, V_FETCH};
        op    = 6'b111111;
        funct = 6'b100000;
        for (int i = 0; i < exp.size(); i++) begin
            if (outs !== exp[i]) begin
                $display("FAIL illegal_op cycle %0d outs got %b expected %b", i, outs, exp[i]);
                errors++;
            end
            checks++;
            if (i < exp.size() - 1) begin
                @(negedge clk);
                #1;
            end
        end
    endtask

    task automatic test_reset_mid_memwr();
        logic [15:0] exp [$];
        exp = '{V_FETCH, V_DECODE, V_MEMADR, V_MEMWR};
        op    = 6'b101011;
        funct = 6'b000000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
        end
        if (outs !== V_MEMWR) begin
            $display("FAIL pre_reset_memwr outs got %b expected %b", outs, V_MEMWR);
            errors++;
        end
        checks++;
        reset = 1'b1;
        #1;
        if (outs !== V_FETCH) begin
            $display("FAIL reset_mid_memwr outs got %b expected %b", outs, V_FETCH);
            errors++;
        end
        checks++;
        @(negedge clk);
        reset = 1'b0;
        #1;
        for (int i = 0; i < exp.size(); i++) begin
            if (outs !== exp[i]) begin
                $display("FAIL after_reset cycle %0d outs got %b expected %b", i, outs, exp[i]);
                errors++;
            end
            checks++;
            @(negedge clk);
            #1;
        end
        if (outs !== V_FETCH) begin
            $display("FAIL after_reset_done outs got %b expected %b", outs, V_FETCH);
            errors++;
        end
        checks++;
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw();
        test_rtype();
        test_beq(1'b1);
        test_beq(1'b0);
        test_j_addi();
        test_illegal_op();
        test_reset_mid_memwr();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Main control unit of the multicycle MIPS core: a Moore state machine that sequences each instruction through fetch, decode, execute, memory and writeback cycles. It decodes the opcode and funct fields of the registered instruction and drives every select and enable input of the multicycle datapath. It consumes the datapath's ALU `zero` flag to resolve branches. Supported instructions: lw, sw, R-type (add, sub, and, or, slt), beq, addi, j.

## Interface
No parameters.
- clk  in  1  rising-edge clock, shared with the datapath
- reset  in  1  asynchronous, active-high; forces state to FETCH
- op  in  6  instr[31:26] from the instruction register
- funct  in  6  instr[5:0]
- zero  in  1  ALU zero flag from the datapath, combinational in the same cycle
- pcen  out  1  PC load enable; equals pcwrite OR (branch AND zero)
- memwrite  out  1  memory write strobe
- irwrite  out  1  instruction register load
- regwrite  out  1  register file write
- alusrca  out  1  0 = PC, 1 = register A
- iord  out  1  0 = PC address, 1 = aluout address
- memtoreg  out  1  0 = aluout, 1 = readdata
- regdst  out  1  0 = rt, 1 = rd
- alusrcb  out  2  00 = regB, 01 = constant 4, 10 = signimm, 11 = signimm<<2
- pcsrc  out  2  00 = aluresult, 01 = aluout, 10 = jump target
- alucont  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- illegal  out  1  single-cycle pulse on an unsupported opcode or funct

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BEQEX, ADDIEX, ADDIWB, JEX.
- Any output not listed for a state is 0. alucont defaults to 010.
- FETCH:
  - Outputs: irwrite=1, pcwrite=1, alusrca=0, alusrcb=01, iord=0, pcsrc=00.
  - Next state: DECODE.
- DECODE:
  - Outputs: alusrca=0, alusrcb=11. This precomputes the branch target into aluout.
  - Next state by op: lw/sw (100011/101011) -> MEMADR; R-type (000000) -> RTYPEEX; beq (000100) -> BEQEX; addi (001000) -> ADDIEX; j (000010) -> JEX.
  - Any other op: illegal=1 and next state FETCH, so the instruction executes as a NOP.
- MEMADR:
  - Outputs: alusrca=1, alusrcb=10.
  - Next state: MEMRD for lw, MEMWR for sw.
- MEMRD: iord=1 -> MEMWB.
- MEMWB: regwrite=1, memtoreg=1, regdst=0 -> FETCH.
- MEMWR: iord=1, memwrite=1 -> FETCH.
- RTYPEEX:
  - Outputs: alusrca=1, alusrcb=00, alucont from funct.
  - funct decode: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
  - Unknown funct: illegal=1 and alucont=010.
  - Next state: RTYPEWB.
- RTYPEWB: regwrite=1, regdst=1, memtoreg=0 -> FETCH. This state is entered even after an illegal funct.
- BEQEX:
  - Outputs: alusrca=1, alusrcb=00, alucont=110, pcsrc=01, branch=1.
  - pcen follows zero combinationally in this cycle.
  - Next state: FETCH.
- ADDIEX: alusrca=1, alusrcb=10 -> ADDIWB.
- ADDIWB: regwrite=1, regdst=0, memtoreg=0 -> FETCH.
- JEX: pcwrite=1, pcsrc=10 -> FETCH.
- Unreachable state encodings go to FETCH.

## Timing
- State register updates on posedge clk and resets asynchronously to FETCH.
- All outputs are decoded from the state register and op/funct; there is no output register.
- pcen is the only output that also depends on zero.
- While reset is high, outputs equal the FETCH values: pcen=1, irwrite=1, alusrcb=01, alucont=010, all others 0. This is harmless because the datapath PC is held in reset.
- Cycles per instruction: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal op 2.
- op and funct must be stable from DECODE to instruction completion. irwrite is asserted only in FETCH.
- Reset asserted mid-instruction returns the FSM to FETCH immediately. No write strobe is asserted after the reset edge.

## Structure
- Shared package `mips_pkg` holds:
  - the state enum `ctrl_state_t`
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J
  - funct constants
  - alucont constants: ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT
  - select encodings for alusrcb and pcsrc
- Sub-module `alu_decoder`: combinational map of (aluop[1:0], funct) -> (alucont, illegal_funct).
  - aluop 00 = add, 01 = sub, 10 = use funct.
  - The FSM emits aluop per state.

## Test plan
- Reset then lw (op=100011): states FETCH, DECODE, MEMADR, MEMRD, MEMWB. irwrite=1 only in cycle 0. regwrite=1, memtoreg=1 only in cycle 4. Back in FETCH at cycle 5.
- sw (op=101011): memwrite=1 with iord=1 exactly in cycle 3, regwrite never asserted, 4 cycles total.
- R-type with each funct 100000/100010/100100/100101/101010: alucont in RTYPEEX is 010/110/000/001/111. RTYPEWB has regdst=1, regwrite=1.
- beq: with zero=1 in BEQEX, pcen=1 and pcsrc=01. With zero=0, pcen=0. Next state is FETCH in both cases.
- j and addi: j gives pcen=1, pcsrc=10 in cycle 2. addi gives alusrcb=10 in ADDIEX, then regwrite=1 with regdst=0 in ADDIWB.
- op=111111: illegal pulses for one cycle in DECODE and the FSM returns to FETCH. Separately, reset asserted during MEMWR causes memwrite to drop asynchronously, and the state is FETCH after release.
